// File: rtl/round_sequencer.sv
// Turn/round scheduler for the two-player mental-math game: requests a target,
// runs the digit timer, judges each answer and keeps scores and rounds.
module round_sequencer #(
    parameter int NUM_ROUNDS = 8,
    parameter int DIGIT_W    = 4,
    parameter int SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Logged_In,
    input  logic               Start,
    input  logic [DIGIT_W-1:0] RNG_Value,
    input  logic               RNG_Valid,
    output logic               RNG_Gen,
    output logic               Timer_reconfig,
    output logic               Timer_enable,
    input  logic               DigitTime_Out,
    input  logic [DIGIT_W-1:0] Answer,
    input  logic               Answer_Valid,
    output logic               Player_Sel,
    output logic [SCORE_W-1:0] Score_P1,
    output logic [SCORE_W-1:0] Score_P2,
    output logic [3:0]         Round_Cnt,
    output logic               Correct,
    output logic               Game_Over,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GEN      = 3'd1,
        S_WAIT_RNG = 3'd2,
        S_ARM      = 3'd3,
        S_PLAY     = 3'd4,
        S_SCORE    = 3'd5,
        S_NEXT     = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
    localparam logic [3:0]         ROUNDS_L  = 4'(NUM_ROUNDS);

    state_t             state;
    state_t             next_state;
    logic [DIGIT_W-1:0] target;
    logic [DIGIT_W-1:0] target_d;
    logic [SCORE_W-1:0] score_p1_d;
    logic [SCORE_W-1:0] score_p2_d;
    logic [3:0]         round_cnt_d;
    logic               player_sel_d;
    logic               correct_d;
    logic               start_ok;
    logic               hit;
    logic [3:0]         round_inc;

    assign start_ok  = Start & Logged_In;
    assign hit       = Answer_Valid && (Answer == target);
    assign round_inc = Round_Cnt + 4'd1;
    assign state_dbg = state;

    // State and all outputs are registered; strobes decode the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            target         <= '0;
            Score_P1       <= '0;
            Score_P2       <= '0;
            Round_Cnt      <= '0;
            Player_Sel     <= 1'b0;
            Correct        <= 1'b0;
            RNG_Gen        <= 1'b0;
            Timer_reconfig <= 1'b0;
            Timer_enable   <= 1'b0;
            Game_Over      <= 1'b0;
        end else begin
            state          <= next_state;
            target         <= target_d;
            Score_P1       <= score_p1_d;
            Score_P2       <= score_p2_d;
            Round_Cnt      <= round_cnt_d;
            Player_Sel     <= player_sel_d;
            Correct        <= correct_d;
            RNG_Gen        <= (next_state == S_GEN);
            Timer_reconfig <= (next_state == S_ARM);
            Timer_enable   <= (next_state == S_PLAY);
            Game_Over      <= (next_state == S_DONE);
        end
    end

    always_comb begin
        next_state = state;
        if (state != S_IDLE && !Logged_In) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:     if (start_ok) next_state = S_GEN;
                S_GEN:      next_state = S_WAIT_RNG;
                S_WAIT_RNG: if (RNG_Valid) next_state = S_ARM;
                S_ARM:      next_state = S_PLAY;
                // An answer arriving with the timeout still wins; both just end the turn.
                S_PLAY:     if (Answer_Valid || DigitTime_Out) next_state = S_SCORE;
                S_SCORE:    next_state = S_NEXT;
                S_NEXT:     next_state = (Player_Sel && round_inc == ROUNDS_L) ? S_DONE : S_GEN;
                S_DONE:     if (Start) next_state = S_GEN;
                default:    next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        target_d     = target;
        score_p1_d   = Score_P1;
        score_p2_d   = Score_P2;
        round_cnt_d  = Round_Cnt;
        player_sel_d = Player_Sel;
        correct_d    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (next_state == S_GEN) begin
                    score_p1_d   = '0;
                    score_p2_d   = '0;
                    round_cnt_d  = '0;
                    player_sel_d = 1'b0;
                end
            end
            S_WAIT_RNG: begin
                if (next_state == S_ARM) target_d = RNG_Value;
            end
            S_PLAY: begin
                // Score lands together with Correct as the turn enters SCORE.
                if (next_state == S_SCORE && hit) begin
                    correct_d = 1'b1;
                    if (!Player_Sel) begin
                        if (Score_P1 != SCORE_MAX) score_p1_d = Score_P1 + SCORE_ONE;
                    end else begin
                        if (Score_P2 != SCORE_MAX) score_p2_d = Score_P2 + SCORE_ONE;
                    end
                end
            end
            S_NEXT: begin
                if (next_state != S_IDLE) begin
                    player_sel_d = ~Player_Sel;
                    if (Player_Sel) round_cnt_d = round_inc;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer: a small game model predicts each
// turn's outcome into a queue, compared when the DUT reaches its SCORE cycle.
module tb_round_sequencer;

    localparam int NR = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       Logged_In;
    logic       Start;
    logic [3:0] RNG_Value;
    logic       RNG_Valid;
    logic       DigitTime_Out;
    logic [3:0] Answer;
    logic       Answer_Valid;
    logic       RNG_Gen;
    logic       Timer_reconfig;
    logic       Timer_enable;
    logic       Player_Sel;
    logic [3:0] Score_P1;
    logic [3:0] Score_P2;
    logic [3:0] Round_Cnt;
    logic       Correct;
    logic       Game_Over;
    logic [2:0] state_dbg;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    logic [3:0] m_p1;
    logic [3:0] m_p2;
    logic [3:0] m_round;
    logic       m_player;

    round_sequencer #(.NUM_ROUNDS(NR), .DIGIT_W(4), .SCORE_W(4)) dut (
        .clk(clk), .rst(rst), .Logged_In(Logged_In), .Start(Start),
        .RNG_Value(RNG_Value), .RNG_Valid(RNG_Valid), .RNG_Gen(RNG_Gen),
        .Timer_reconfig(Timer_reconfig), .Timer_enable(Timer_enable),
        .DigitTime_Out(DigitTime_Out), .Answer(Answer), .Answer_Valid(Answer_Valid),
        .Player_Sel(Player_Sel), .Score_P1(Score_P1), .Score_P2(Score_P2),
        .Round_Cnt(Round_Cnt), .Correct(Correct), .Game_Over(Game_Over),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_game();
        @(posedge clk); #1;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        m_p1 = 4'd0; m_p2 = 4'd0; m_round = 4'd0; m_player = 1'b0;
        @(negedge clk);
        check("start_to_gen", RNG_Gen, 1);
        check("clr_scores", {Score_P1, Score_P2}, 0);
        check("clr_round", {Round_Cnt, Player_Sel}, 0);
        check("clr_over", Game_Over, 0);
    endtask

    // Called at a negedge; leaves the DUT in PLAY, sampled at a negedge.
    task automatic run_to_play(input logic [3:0] tgt);
        for (int i = 0; i < 20 && !RNG_Gen; i++) @(negedge clk);
        check("gen_seen", RNG_Gen, 1);
        @(posedge clk); #1;
        RNG_Value = tgt;
        RNG_Valid = 1'b1;
        @(negedge clk);
        check("gen_one_cycle", RNG_Gen, 0);
        @(posedge clk); #1;
        RNG_Valid = 1'b0;
        RNG_Value = 4'($urandom_range(0, 15));
        @(negedge clk);
        check("reconfig", Timer_reconfig, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("enable", Timer_enable, 1);
        check("reconfig_drop", Timer_reconfig, 0);
    endtask

    task automatic finish_turn(input logic [3:0] tgt, input logic [3:0] ans,
                               input logic give_ans, input logic give_to);
        logic       hit;
        logic [8:0] exp;
        Answer        = ans;
        Answer_Valid  = give_ans;
        DigitTime_Out = give_to;
        hit = give_ans && (ans == tgt);
        if (hit) begin
            if (!m_player) begin
                if (m_p1 != 4'hf) m_p1 = m_p1 + 4'd1;
            end else begin
                if (m_p2 != 4'hf) m_p2 = m_p2 + 4'd1;
            end
        end
        exp_q.push_back({hit, m_p1, m_p2});
        @(posedge clk); #1;
        Answer_Valid  = 1'b0;
        DigitTime_Out = 1'b0;
        @(negedge clk);
        check("in_score", state_dbg, 5);
        exp = exp_q.pop_front();
        check("correct", Correct, exp[8]);
        check("score_p1", Score_P1, exp[7:4]);
        check("score_p2", Score_P2, exp[3:0]);
        check("enable_off", Timer_enable, 0);
        if (m_player) m_round = m_round + 4'd1;
        m_player = ~m_player;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("player_sel", Player_Sel, m_player);
        check("round_cnt", Round_Cnt, m_round);
        check("game_over", Game_Over, m_round == NR);
        check("correct_pulse", Correct, 0);
    endtask

    task automatic play_turn(input logic [3:0] tgt, input logic [3:0] ans,
                             input logic give_ans, input logic give_to);
        run_to_play(tgt);
        finish_turn(tgt, ans, give_ans, give_to);
    endtask

    initial begin
        int gen_cnt;
        logic [3:0] t;
        rst = 1'b0; Logged_In = 1'b0; Start = 1'b0;
        RNG_Value = 4'd0; RNG_Valid = 1'b0; DigitTime_Out = 1'b0;
        Answer = 4'd0; Answer_Valid = 1'b0;
        #2;
        check("reset_outputs", {RNG_Gen, Timer_reconfig, Timer_enable, Player_Sel,
                                Score_P1, Score_P2, Round_Cnt, Correct, Game_Over}, 0);
        check("reset_state", state_dbg, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        Logged_In = 1'b1;

        // Game 1: correct, timeout, answer+timeout same cycle, wrong answer.
        start_game();
        play_turn(4'b1010, 4'b1010, 1'b1, 1'b0);
        play_turn(4'b0011, 4'b0000, 1'b0, 1'b1);
        play_turn(4'b0110, 4'b0110, 1'b1, 1'b1);
        play_turn(4'b1100, 4'b1101, 1'b1, 1'b0);

        // Game 2: every answer correct, random targets.
        start_game();
        for (int i = 0; i < 2 * NR; i++) begin
            t = 4'($urandom_range(0, 15));
            play_turn(t, t, 1'b1, 1'b0);
        end
        check("final_p1", Score_P1, 2);
        check("final_p2", Score_P2, 2);

        // Game 3: restart clears, then logout during Player 2's PLAY.
        start_game();
        play_turn(4'b0101, 4'b0101, 1'b1, 1'b0);
        run_to_play(4'b1001);
        Logged_In = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("logout_state", state_dbg, 0);
        check("logout_enable", Timer_enable, 0);
        check("logout_over", Game_Over, 0);
        check("logout_p1_hold", Score_P1, m_p1);
        check("logout_round_hold", Round_Cnt, m_round);
        @(posedge clk); #1;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        gen_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (RNG_Gen) gen_cnt++;
        end
        check("no_gen_logged_out", gen_cnt, 0);
        check("p1_still_held", Score_P1, m_p1);

        // Game 4: asynchronous reset while waiting for the RNG.
        Logged_In = 1'b1;
        start_game();
        play_turn(4'b1111, 4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 20 && !RNG_Gen; i++) @(negedge clk);
        @(posedge clk); #3;
        check("in_wait_rng", state_dbg, 2);
        rst = 1'b0;
        #1;
        check("async_rst_outputs", {RNG_Gen, Timer_reconfig, Timer_enable, Player_Sel,
                                    Score_P1, Score_P2, Round_Cnt, Correct, Game_Over}, 0);
        check("async_rst_state", state_dbg, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        RNG_Value = 4'b0111;
        RNG_Valid = 1'b1;
        @(posedge clk); #1;
        RNG_Valid = 1'b0;
        @(negedge clk);
        check("late_rng_state", state_dbg, 0);
        check("late_rng_reconfig", Timer_reconfig, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Turn/round scheduler for the mental-math binary game. It sits after login authentication and drives the shared random-number generator and digit timer.
- It alternates turns between Player 1 and Player 2 and, on each turn, requests a new target, arms and runs the timer, and judges the player's 4-bit answer.
- It keeps per-player scores and a round count, and flags game over after NUM_ROUNDS full rounds (one turn per player per round).

Parameters:
NUM_ROUNDS, 8, full rounds per game (1..15)
DIGIT_W, 4, width of target and answer
SCORE_W, 4, width of each score counter (saturating)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
Logged_In  in  1  level from authentication; game runs only while high
Start  in  1  single-cycle pulse, begins a new game from IDLE
RNG_Value  in  DIGIT_W  target value from the RNG
RNG_Valid  in  1  pulse, RNG_Value is valid this cycle
RNG_Gen  out  1  single-cycle request to the RNG
Timer_reconfig  out  1  single-cycle timer reload pulse
Timer_enable  out  1  level, timer counts while high
DigitTime_Out  in  1  pulse, the turn's time has expired
Answer  in  DIGIT_W  player's binary answer
Answer_Valid  in  1  pulse, Answer is submitted this cycle
Player_Sel  out  1  0 = Player 1 turn, 1 = Player 2 turn
Score_P1  out  SCORE_W  Player 1 score
Score_P2  out  SCORE_W  Player 2 score
Round_Cnt  out  4  completed full rounds
Correct  out  1  single-cycle pulse in the SCORE state when the answer matched
Game_Over  out  1  level, high in DONE

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE.
  - Every output is 0; the internal target register is 0.
- States (all outputs are registered):
  - IDLE: waits for Start=1 with Logged_In=1. That cycle clears both scores, Round_Cnt and Player_Sel, then goes to GEN. Start while Logged_In=0 is ignored.
  - GEN: RNG_Gen=1 for exactly one cycle, then WAIT_RNG.
  - WAIT_RNG: on RNG_Valid, latch RNG_Value into the target and go to ARM. No timeout applies in this state.
  - ARM: Timer_reconfig=1 for one cycle, then PLAY.
  - PLAY: Timer_enable=1.
    - Answer_Valid: latch whether Answer == target, then go to SCORE.
    - DigitTime_Out without Answer_Valid: the answer is wrong; go to SCORE.
    - Answer_Valid and DigitTime_Out in the same cycle: the answer wins and is judged normally.
    - Answer_Valid outside PLAY is ignored.
  - SCORE: one cycle, Timer_enable=0.
    - If the answer matched: Correct=1 and the active player's score increments, saturating at 2^SCORE_W-1.
    - Then NEXT.
  - NEXT: one cycle.
    - Player_Sel=0: Player_Sel becomes 1; go to GEN.
    - Player_Sel=1: Player_Sel becomes 0 and Round_Cnt increments. If the new Round_Cnt == NUM_ROUNDS go to DONE, otherwise GEN.
  - DONE: Game_Over=1; scores and Round_Cnt hold. Start with Logged_In=1 goes to IDLE-clear behaviour and then GEN directly (same cycle as the IDLE case).
- Minimum turn latency: Start to RNG_Gen is 1 cycle. RNG_Valid to Timer_reconfig is 1 cycle. Timer_reconfig to Timer_enable is 1 cycle. Answer_Valid to Correct is 1 cycle.
- Logout: Logged_In=0 in any state other than IDLE aborts to IDLE on the next edge.
  - Timer_enable, RNG_Gen and Timer_reconfig drop.
  - Scores and Round_Cnt hold until the next Start; Game_Over=0.
- Score width: SCORE_W is at least 4, so NUM_ROUNDS ≤ 15 never saturates in normal play. Saturation must still be implemented.
- Stray pulses: RNG_Valid outside WAIT_RNG and DigitTime_Out outside PLAY are ignored.

Test Plan:
- Reset, Start pulse with Logged_In=1, RNG returns 4'b1010, Answer=4'b1010 → RNG_Gen then Timer_reconfig each high one cycle. Correct pulses, Score_P1=1, Player_Sel=1.
- Player 2 turn with target 4'b0011, no answer, DigitTime_Out pulse → Correct stays 0, Score_P2=0, Round_Cnt=1, Player_Sel=0.
- Answer_Valid (correct) and DigitTime_Out in the same PLAY cycle → Correct=1 and the score increments.
- NUM_ROUNDS=2, all answers correct → Game_Over=1 after 4 turns, Score_P1=2, Score_P2=2, Round_Cnt=2. A further Start restarts with scores 0.
- Logged_In falls during PLAY → next cycle state IDLE, Timer_enable=0, Game_Over=0, scores held. Start with Logged_In=0 gives no RNG_Gen.
- rst asserted mid-WAIT_RNG (asynchronous, between edges) → all outputs 0 immediately. A late RNG_Valid after release has no effect.
